// File: rtl/comp_arb_pkg.sv
// Shared types and constants for the two-channel compare arbiter.
//   OP_W    : operand width of the shared comparator
//   state_t : arbiter FSM states
package comp_arb_pkg;

    localparam int unsigned OP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/comp_arb_2ch_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
//   req0_* / req1_* : per-channel valid, operands a/b, ready (ready driven by arbiter)
//   rsp_*           : result valid/ready, owning channel id, gt/lt/eq flags
//   busy            : arbiter not idle
//   cnt0 / cnt1     : completed-response counters (CNT_W bits)
// Modports: slave = arbiter side, master = requester/consumer side.
interface comp_arb_2ch_if #(
    parameter int unsigned CNT_W = 16
);

    logic                             req0_valid;
    logic [comp_arb_pkg::OP_W-1:0]    req0_a;
    logic [comp_arb_pkg::OP_W-1:0]    req0_b;
    logic                             req0_ready;

    logic                             req1_valid;
    logic [comp_arb_pkg::OP_W-1:0]    req1_a;
    logic [comp_arb_pkg::OP_W-1:0]    req1_b;
    logic                             req1_ready;

    logic                             rsp_valid;
    logic                             rsp_ready;
    logic                             rsp_id;
    logic                             rsp_gt;
    logic                             rsp_lt;
    logic                             rsp_eq;

    logic                             busy;
    logic [CNT_W-1:0]                 cnt0;
    logic [CNT_W-1:0]                 cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq,
        output busy, cnt0, cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq,
        input  busy, cnt0, cnt1
    );

endinterface

// File: rtl/comp_arb_2ch_comp_8bit.sv
// Unsigned magnitude comparator (module comp_8bit), purely combinational.
//   i_a, i_b          : operands
//   o_gt, o_lt, o_eq  : a>b, a<b, a==b (exactly one high)
module comp_8bit
    import comp_arb_pkg::*;
(
    input  logic [OP_W-1:0] i_a,
    input  logic [OP_W-1:0] i_b,
    output logic            o_gt,
    output logic            o_lt,
    output logic            o_eq
);

    assign o_gt = (i_a >  i_b);
    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/comp_arb_2ch.sv
// Two-channel round-robin arbiter sharing one comparator (IDLE -> CMP -> RESP).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : comp_arb_2ch_if.slave (request channels, response, busy, counters)
// reqN_ready is combinational in IDLE; all other outputs are registered.
// Optional feature: define COMP_ARB_STATS_EN to enable saturating per-channel
// response counters; otherwise cnt0/cnt1 are tied to zero.
module comp_arb_2ch
    import comp_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    comp_arb_2ch_if.slave  bus
);

    state_t          r_state;
    logic            r_last;
    logic            r_id;
    logic [OP_W-1:0] r_a;
    logic [OP_W-1:0] r_b;
    logic            r_gt;
    logic            r_lt;
    logic            r_eq;
    logic            r_rsp_valid;
    logic            r_busy;

    logic            w_any;
    logic            w_gnt_id;
    logic            w_accept;
    logic            w_rsp_hs;
    logic            w_gt;
    logic            w_lt;
    logic            w_eq;

    // Grant: a lone requester wins; on a tie the channel not granted last wins.
    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_gnt_id = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    assign w_accept = (r_state == IDLE) & w_any;
    assign w_rsp_hs = (r_state == RESP) & bus.rsp_ready;

    assign bus.req0_ready = w_accept & ~w_gnt_id;
    assign bus.req1_ready = w_accept &  w_gnt_id;

    comp_8bit u_cmp (
        .i_a  (r_a),
        .i_b  (r_b),
        .o_gt (w_gt),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    // Arbiter FSM; last-grant resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt_id ? bus.req1_a : bus.req0_a;
                        r_b     <= w_gnt_id ? bus.req1_b : bus.req0_b;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_busy  <= 1'b1;
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    r_gt        <= w_gt;
                    r_lt        <= w_lt;
                    r_eq        <= w_eq;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_gt    = r_gt;
    assign bus.rsp_lt    = r_lt;
    assign bus.rsp_eq    = r_eq;
    assign bus.busy      = r_busy;

`ifdef COMP_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Count completed handshakes per owning channel, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_rsp_hs) begin
            if (!r_id && !(&r_cnt0)) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if ( r_id && !(&r_cnt1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign bus.cnt0 = r_cnt0;
    assign bus.cnt1 = r_cnt1;
`else
    assign bus.cnt0 = CNT_W'(0);
    assign bus.cnt1 = CNT_W'(0);
`endif

endmodule

// File: tb/tb_comp_arb_2ch.sv
// Self-checking bench for comp_arb_2ch: queue-fed requesters, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_comp_arb_2ch;
    import comp_arb_pkg::*;

`ifdef COMP_ARB_STATS_EN
    localparam int unsigned CNT_W = 2;
    localparam bit          STATS = 1'b1;
`else
    localparam int unsigned CNT_W = 16;
    localparam bit          STATS = 1'b0;
`endif

    typedef struct { int ch; int cyc; } gnt_t;
    typedef struct { int id; logic [2:0] f; int cyc; } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    comp_arb_2ch_if #(.CNT_W(CNT_W)) bus ();

    comp_arb_2ch #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    gnt_t        glog[$];
    rsp_t        rlog[$];
    int          rr_mode = 0;
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;

    // reference model state (transaction level)
    logic             m_txn  = 1'b0;
    int               m_acc  = 0;
    logic             m_id   = 1'b0;
    logic             m_last = 1'b1;
    logic [2:0]       m_flags = 3'b000;
    logic [CNT_W-1:0] m_cnt0 = '0;
    logic [CNT_W-1:0] m_cnt1 = '0;
    logic             g;
    logic             e0;
    logic             e1;
    logic             ev;
    logic [7:0]       ma;
    logic [7:0]       mb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requesters pop from their queues and hold valid until accepted; consumer ready per mode.
    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.req0_valid || hs0) begin
                if (q0.size() > 0) begin
                    {bus.req0_a, bus.req0_b} = q0.pop_front();
                    bus.req0_valid = 1'b1;
                end else bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid || hs1) begin
                if (q1.size() > 0) begin
                    {bus.req1_a, bus.req1_b} = q1.pop_front();
                    bus.req1_valid = 1'b1;
                end else bus.req1_valid = 1'b0;
            end
            case (rr_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Compare process: model expectations for this cycle, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_txn = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
            hs0 = 1'b0; hs1 = 1'b0;
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_busy",      32'(bus.busy),      32'd0);
            chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
            chk("rst_flags",     32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'd0);
            chk("rst_cnt0",      32'(bus.cnt0),      32'd0);
            chk("rst_cnt1",      32'(bus.cnt1),      32'd0);
        end else begin
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            if (!m_txn) begin
                e0 = 1'b0; e1 = 1'b0;
                if (bus.req0_valid || bus.req1_valid) begin
                    g  = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
                    e0 = !g; e1 = g;
                    ma = g ? bus.req1_a : bus.req0_a;
                    mb = g ? bus.req1_b : bus.req0_b;
                    m_flags = {ma > mb, ma < mb, ma == mb};
                    m_txn = 1'b1; m_acc = cyc; m_id = g; m_last = g;
                    glog.push_back('{int'(g), cyc});
                end
                chk("ready0",    32'(bus.req0_ready), 32'(e0));
                chk("ready1",    32'(bus.req1_ready), 32'(e1));
                chk("busy_idle", 32'(bus.busy),       32'd0);
                chk("rsp_valid", 32'(bus.rsp_valid),  32'd0);
            end else begin
                chk("ready0_busy", 32'(bus.req0_ready), 32'd0);
                chk("ready1_busy", 32'(bus.req1_ready), 32'd0);
                chk("busy",        32'(bus.busy),       32'd1);
                ev = (cyc >= m_acc + 2);
                chk("rsp_valid",   32'(bus.rsp_valid),  32'(ev));
                if (ev) begin
                    chk("rsp_id",    32'(bus.rsp_id), 32'(m_id));
                    chk("rsp_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'(m_flags));
                    if (bus.rsp_ready) begin
                        rlog.push_back('{int'(bus.rsp_id), {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, cyc});
                        m_txn = 1'b0;
                        if (STATS) begin
                            if (!m_id && m_cnt0 != {CNT_W{1'b1}}) m_cnt0 = m_cnt0 + CNT_W'(1);
                            if ( m_id && m_cnt1 != {CNT_W{1'b1}}) m_cnt1 = m_cnt1 + CNT_W'(1);
                        end
                    end
                end
            end
            chk("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
            chk("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        end
    end

    task automatic do_reset();
        @(posedge clk); #2; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        @(posedge clk); #3;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            done = (q0.size() == 0) && (q1.size() == 0) && !bus.req0_valid &&
                   !bus.req1_valid && !m_txn;
        end
        chk("wait_idle_timeout", 32'(done), 32'd1);
    endtask

    int          g0;
    int          r0;
    bit          ok;
    logic [7:0]  ra;
    logic [7:0]  rb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // power-on reset
        repeat (3) @(posedge clk);
        chk("por_busy",      32'(bus.busy),      32'd0);
        chk("por_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #2; rst_n = 1'b1;
        @(posedge clk); #3;

        // single ch0 request: 30 vs 8
        rr_mode = 0; g0 = glog.size(); r0 = rlog.size();
        q0.push_back({8'd30, 8'd8});
        wait_idle(20);
        chk("t1_nrsp",    32'(rlog.size() - r0), 32'd1);
        chk("t1_gnt_ch",  32'(glog[g0].ch), 32'd0);
        chk("t1_rsp_id",  32'(rlog[r0].id), 32'd0);
        chk("t1_flags",   32'(rlog[r0].f),  32'b100);
        chk("t1_latency", 32'(rlog[r0].cyc - glog[g0].cyc), 32'd2);

        // simultaneous tie after reset: ch0 first
        do_reset();
        g0 = glog.size(); r0 = rlog.size();
        q0.push_back({8'd0, 8'd30});
        q1.push_back({8'd16, 8'd16});
        wait_idle(30);
        chk("t2_nrsp",   32'(rlog.size() - r0), 32'd2);
        chk("t2_gnt0",   32'(glog[g0].ch),     32'd0);
        chk("t2_gnt1",   32'(glog[g0 + 1].ch), 32'd1);
        chk("t2_id0",    32'(rlog[r0].id),     32'd0);
        chk("t2_f0",     32'(rlog[r0].f),      32'b010);
        chk("t2_id1",    32'(rlog[r0 + 1].id), 32'd1);
        chk("t2_f1",     32'(rlog[r0 + 1].f),  32'b001);
        chk("t2_cnt0",   32'(bus.cnt0),        32'(STATS));

        // continuous contention: alternate grants, one response every 3 cycles
        do_reset();
        g0 = glog.size(); r0 = rlog.size();
        q0.push_back({8'd1, 8'd2}); q0.push_back({8'd9, 8'd3});
        q1.push_back({8'd7, 8'd7}); q1.push_back({8'd200, 8'd201});
        wait_idle(40);
        chk("t3_nrsp", 32'(rlog.size() - r0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_gnt_order", 32'(glog[g0 + k].ch), 32'(k % 2));
            chk("t3_rsp_order", 32'(rlog[r0 + k].id), 32'(k % 2));
        end
        for (int k = 0; k < 3; k++)
            chk("t3_rsp_spacing", 32'(rlog[r0 + k + 1].cyc - rlog[r0 + k].cyc), 32'd3);

        // consumer stalls in RESP; second channel must wait
        do_reset();
        rr_mode = 2; g0 = glog.size(); r0 = rlog.size();
        q0.push_back({8'd10, 8'd20});
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1; ok = bus.rsp_valid;
        end
        chk("t4_rsp_seen", 32'(ok), 32'd1);
        q1.push_back({8'd5, 8'd5});
        repeat (5) @(negedge clk);
        rr_mode = 0;
        wait_idle(30);
        chk("t4_nrsp",     32'(rlog.size() - r0), 32'd2);
        chk("t4_f0",       32'(rlog[r0].f), 32'b010);
        chk("t4_hold",     32'(rlog[r0].cyc - glog[g0].cyc), 32'd8);
        chk("t4_gnt1_ch",  32'(glog[g0 + 1].ch), 32'd1);
        chk("t4_gnt1_cyc", 32'(glog[g0 + 1].cyc - rlog[r0].cyc), 32'd1);

        // reset during CMP discards the transaction
        do_reset();
        g0 = glog.size(); r0 = rlog.size();
        q0.push_back({8'd7, 8'd3});
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1; ok = (glog.size() > g0);
        end
        chk("t5_granted", 32'(ok), 32'd1);
        @(posedge clk); #2; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_rsp", 32'(rlog.size() - r0), 32'd0);
        q0.push_back({8'd200, 8'd100});
        wait_idle(20);
        chk("t5_nrsp",  32'(rlog.size() - r0), 32'd1);
        chk("t5_flags", 32'(rlog[r0].f), 32'b100);

        // five ch1 responses: counter saturates when stats are on
        do_reset();
        for (int k = 0; k < 5; k++) q1.push_back({8'(k), 8'd2});
        wait_idle(40);
        chk("t6_cnt1", 32'(bus.cnt1), STATS ? 32'd3 : 32'd0);
        chk("t6_cnt0", 32'(bus.cnt0), 32'd0);

        // randomized traffic with a randomly stalling consumer
        do_reset();
        rr_mode = 1;
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            case ($urandom_range(0, 2))
                0:       q0.push_back({ra, rb});
                1:       q1.push_back({ra, rb});
                default: begin q0.push_back({ra, rb}); q1.push_back({rb, ra}); end
            endcase
        end
        wait_idle(3000);
        rr_mode = 0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
